// File: rtl/mm_pkg.sv
// Shared types and defaults for the mm_tile_engine matrix-multiply slice.
package mm_pkg;
  localparam int unsigned LANES_DEF  = 8;
  localparam int unsigned ELEM_W_DEF = 32;

  localparam logic signed [ELEM_W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(ELEM_W_DEF-1){1'b1}}};
  localparam logic signed [ELEM_W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(ELEM_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LD_A,
    S_LD_B,
    S_ST_C
  } state_t;
endpackage

// File: rtl/mm_mac_lane.sv
// Single-lane signed multiply-accumulate with clear and enable.
// MM_SATURATE_EN selects per-step clamping; otherwise two's-complement wrap.
module mm_mac_lane
  import mm_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] acc
);
  logic [ELEM_W-1:0] acc_next;

`ifdef MM_SATURATE_EN
  localparam logic signed [2*ELEM_W:0] SUM_MAX = {{(ELEM_W+2){1'b0}}, {(ELEM_W-1){1'b1}}};
  localparam logic signed [2*ELEM_W:0] SUM_MIN = {{(ELEM_W+2){1'b1}}, {(ELEM_W-1){1'b0}}};

  logic [2*ELEM_W-1:0]      prod;
  logic signed [2*ELEM_W:0] sum;

  // Exact product and sum, one guard bit wider than the full product.
  assign prod = {{ELEM_W{a[ELEM_W-1]}}, a} * {{ELEM_W{b[ELEM_W-1]}}, b};
  assign sum  = $signed({prod[2*ELEM_W-1], prod}) + $signed({{(ELEM_W+1){acc[ELEM_W-1]}}, acc});

  always_comb begin
    acc_next = sum[ELEM_W-1:0];
    if (sum > SUM_MAX) begin
      acc_next = {1'b0, {(ELEM_W-1){1'b1}}};
    end else if (sum < SUM_MIN) begin
      acc_next = {1'b1, {(ELEM_W-1){1'b0}}};
    end
  end
`else
  assign acc_next = acc + a * b;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end
endmodule

// File: rtl/mm_tile_engine.sv
// Matrix-multiply engine C = A x B over a req/ack word port, LANES elements per word.
// Optional per-step saturation via MM_SATURATE_EN (see mm_mac_lane).
module mm_tile_engine
  import mm_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 11,
  localparam int unsigned DW    = LANES * ELEM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_c_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata
);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t state, state_next;

  logic [DIM_W-1:0]  m_q, kw_q, nw_q, i_q, jc_q, kc_q;
  logic [LW-1:0]     l_q;
  logic [ADDR_W-1:0] b_base_q, a_row_q, b_ptr_q, c_ptr_q;
  logic [DW-1:0]     a_word_q, acc_word;
  logic [ELEM_W-1:0] a_elem;
  logic              cfg_ok, accept, reject;
  logic              last_l, last_kc, last_jc, last_i;
  logic              acc_clr, acc_en;

  assign cfg_ok = (cfg_m != '0) && (cfg_k != '0) && (cfg_n != '0) &&
                  ((cfg_k % DIM_W'(LANES)) == '0) && ((cfg_n % DIM_W'(LANES)) == '0);
  assign accept = (state == S_IDLE) && start && cfg_ok;
  assign reject = (state == S_IDLE) && start && !cfg_ok;

  assign last_l  = (l_q == LW'(LANES - 1));
  assign last_kc = (kc_q == kw_q - DIM_W'(1));
  assign last_jc = (jc_q == nw_q - DIM_W'(1));
  assign last_i  = (i_q == m_q - DIM_W'(1));

  assign a_elem  = a_word_q[l_q*ELEM_W +: ELEM_W];
  assign acc_clr = accept || ((state == S_ST_C) && mem_ack);
  assign acc_en  = (state == S_LD_B) && mem_ack;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    mm_mac_lane #(.ELEM_W(ELEM_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (acc_clr),
      .en    (acc_en),
      .a     (a_elem),
      .b     (mem_rdata[j*ELEM_W +: ELEM_W]),
      .acc   (acc_word[j*ELEM_W +: ELEM_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request/address are decoded from registered state so reset clears them at once.
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    mem_req    = (state != S_IDLE);
    mem_we     = (state == S_ST_C);
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_IDLE: if (accept) state_next = S_LD_A;
      S_LD_A: begin
        mem_addr = a_row_q + ADDR_W'(kc_q);
        if (mem_ack) state_next = S_LD_B;
      end
      S_LD_B: begin
        mem_addr = b_ptr_q;
        if (mem_ack && last_l) state_next = last_kc ? S_ST_C : S_LD_A;
      end
      S_ST_C: begin
        mem_addr  = c_ptr_q;
        mem_wdata = acc_word;
        if (mem_ack) state_next = (last_jc && last_i) ? S_IDLE : S_LD_A;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Running pointers replace the i*(K/LANES) and (kc*LANES+l)*(N/LANES) products.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done     <= 1'b0;
      err      <= 1'b0;
      m_q      <= '0;
      kw_q     <= '0;
      nw_q     <= '0;
      i_q      <= '0;
      jc_q     <= '0;
      kc_q     <= '0;
      l_q      <= '0;
      b_base_q <= '0;
      a_row_q  <= '0;
      b_ptr_q  <= '0;
      c_ptr_q  <= '0;
      a_word_q <= '0;
    end else begin
      done <= 1'b0;
      err  <= reject;
      case (state)
        S_IDLE: if (accept) begin
          m_q      <= cfg_m;
          kw_q     <= cfg_k / DIM_W'(LANES);
          nw_q     <= cfg_n / DIM_W'(LANES);
          i_q      <= '0;
          jc_q     <= '0;
          kc_q     <= '0;
          l_q      <= '0;
          b_base_q <= cfg_b_base;
          a_row_q  <= cfg_a_base;
          b_ptr_q  <= cfg_b_base;
          c_ptr_q  <= cfg_c_base;
        end
        S_LD_A: if (mem_ack) begin
          a_word_q <= mem_rdata;
          l_q      <= '0;
        end
        S_LD_B: if (mem_ack) begin
          b_ptr_q <= b_ptr_q + ADDR_W'(nw_q);
          if (last_l) begin
            l_q  <= '0;
            kc_q <= last_kc ? '0 : kc_q + DIM_W'(1);
          end else begin
            l_q <= l_q + LW'(1);
          end
        end
        S_ST_C: if (mem_ack) begin
          c_ptr_q <= c_ptr_q + ADDR_W'(1);
          if (last_jc) begin
            jc_q    <= '0;
            i_q     <= i_q + DIM_W'(1);
            a_row_q <= a_row_q + ADDR_W'(kw_q);
            b_ptr_q <= b_base_q;
            done    <= last_i;
          end else begin
            jc_q    <= jc_q + DIM_W'(1);
            b_ptr_q <= b_base_q + ADDR_W'(jc_q) + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_tile_engine.sv
// Self-checking bench for mm_tile_engine: memory responder with wait states plus a reference model.
module tb_mm_tile_engine;
  localparam int LANES = 8, EW = 32, AW = 32, DIMW = 11, DW = LANES * EW;
  localparam logic [AW-1:0] A_BASE = 32'h0000_0100, B_BASE = 32'h0000_1000, C_BASE = 32'h0000_8000;

  logic clk = 1'b0;
  logic reset, start, busy, done, err, mem_req, mem_we, mem_ack;
  logic [DIMW-1:0] cfg_m, cfg_k, cfg_n;
  logic [AW-1:0]   cfg_a_base, cfg_b_base, cfg_c_base, mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  mm_tile_engine #(.LANES(LANES), .ELEM_W(EW), .ADDR_W(AW), .DIM_W(DIMW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] store_log[$];
  int n_tests = 0, n_fail = 0;
  int max_wait = 0, ack_limit = -1, acks = 0, stab_bad = 0;
  int unsigned ea[], eb[], ec[];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory slave: acks after a random 0..max_wait delay, checks request stability while waiting.
  initial begin : responder
    int wl;
    logic held;
    logic [AW-1:0] ha;
    logic hwe;
    logic [DW-1:0] hwd;
    mem_ack = 1'b0; mem_rdata = '0; held = 1'b0; wl = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req !== 1'b1) begin
        held = 1'b0;
      end else begin
        if (!held) begin
          held = 1'b1; ha = mem_addr; hwe = mem_we; hwd = mem_wdata;
          wl = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        end else if (mem_addr !== ha || mem_we !== hwe || mem_wdata !== hwd) begin
          stab_bad++;
        end
        if (wl == 0 && (ack_limit < 0 || acks < ack_limit)) begin
          mem_ack = 1'b1; held = 1'b0; acks++;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            store_log.push_back(mem_addr);
          end else begin
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
          end
        end else if (wl > 0) begin
          wl--;
        end
      end
    end
  end

  // mode 0: A=identity, B[r][c]=r*N+c; 1: A=1, B=2; 2: A=0x7FFFFFFF, B=2; 3: random.
  task automatic load(input int m, input int k, input int n, input int mode);
    logic [DW-1:0] w;
    longint acc, prod;
    ea = new[m * k]; eb = new[k * n]; ec = new[m * n];
    for (int i = 0; i < m; i++)
      for (int c = 0; c < k; c++)
        ea[i*k+c] = (mode == 0) ? ((i == c) ? 1 : 0) : (mode == 1) ? 1 : (mode == 2) ? 32'h7FFF_FFFF : $urandom;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < n; c++)
        eb[r*n+c] = (mode == 0) ? r * n + c : (mode == 3) ? $urandom : 2;
    for (int i = 0; i < m; i++)
      for (int kc = 0; kc < k / LANES; kc++) begin
        for (int j = 0; j < LANES; j++) w[j*EW +: EW] = ea[i*k + kc*LANES + j];
        mem[A_BASE + AW'(i*(k/LANES) + kc)] = w;
      end
    for (int r = 0; r < k; r++)
      for (int jc = 0; jc < n / LANES; jc++) begin
        for (int j = 0; j < LANES; j++) w[j*EW +: EW] = eb[r*n + jc*LANES + j];
        mem[B_BASE + AW'(r*(n/LANES) + jc)] = w;
      end
    for (int x = 0; x < m * n / LANES; x++) mem[C_BASE + AW'(x)] = {LANES{32'hDEAD_BEEF}};
    for (int i = 0; i < m; i++)
      for (int c = 0; c < n; c++) begin
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          prod = longint'(int'(ea[i*k+kk])) * longint'(int'(eb[kk*n+c]));
`ifdef MM_SATURATE_EN
          acc = acc + prod;
          if (acc > 64'sd2147483647) acc = 64'sd2147483647;
          if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
          acc = longint'(int'(acc + prod));
`endif
        end
        ec[i*n+c] = int'(acc);
      end
  endtask

  task automatic go(input int m, input int k, input int n, input bit expect_ok);
    @(negedge clk);
    cfg_m = DIMW'(m); cfg_k = DIMW'(k); cfg_n = DIMW'(n);
    cfg_a_base = A_BASE; cfg_b_base = B_BASE; cfg_c_base = C_BASE;
    acks = 0; stab_bad = 0; store_log.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (expect_ok) begin
      chk("req_at_t1", mem_req, 1'b1);
      chk("busy_at_t1", busy, 1'b1);
    end else begin
      chk("err_at_t1", err, 1'b1);
      chk("err_busy", busy, 1'b0);
      chk("err_req", mem_req, 1'b0);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
  endtask

  task automatic check_c(input int m, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < m; i++)
      for (int jc = 0; jc < n / LANES; jc++) begin
        for (int j = 0; j < LANES; j++) w[j*EW +: EW] = ec[i*n + jc*LANES + j];
        chk("c_word", mem[C_BASE + AW'(i*(n/LANES) + jc)], w);
      end
  endtask

  function automatic int n_access(input int m, input int k, input int n);
    return m * (n / LANES) * ((k / LANES) * (LANES + 1) + 1);
  endfunction

  initial begin : main
    int cyc, bad, m, k, n;
    logic [DW-1:0] w;
    logic [EW-1:0] e0;
    reset = 1'b0; start = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0; cfg_a_base = '0; cfg_b_base = '0; cfg_c_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wdata, '0);
    @(negedge clk); reset = 1'b1;

    // Identity x B, zero wait: exact latency and access count.
    load(8, 8, 8, 0);
    go(8, 8, 8, 1'b1);
    wait_done(cyc);
    chk("done_latency", cyc, 81);
    chk("accesses_8x8", acks, 80);
    check_c(8, 8);
    for (int x = 0; x < 8; x++) chk("c_eq_b", mem[C_BASE + AW'(x)], mem[B_BASE + AW'(x)]);
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);

    // Same product with random wait states.
    max_wait = 3;
    load(8, 8, 8, 0);
    go(8, 8, 8, 1'b1);
    wait_done(cyc);
    chk("accesses_wait", acks, 80);
    chk("stable_wait", stab_bad, 0);
    check_c(8, 8);

    // All ones times all twos; store order.
    max_wait = 0;
    load(2, 16, 16, 1);
    go(2, 16, 16, 1'b1);
    wait_done(cyc);
    chk("accesses_2x16", acks, n_access(2, 16, 16));
    chk("store_count", store_log.size(), 4);
    for (int x = 0; x < store_log.size(); x++) chk("store_addr", store_log[x], C_BASE + AW'(x));
    check_c(2, 16);
    w = mem[C_BASE]; e0 = w[EW-1:0];
    chk("sum_32", e0, 32'd32);

    // Descriptor errors.
    go(1, 6, 8, 1'b0);
    go(1, 8, 0, 1'b0);
    bad = 0;
    for (int x = 0; x < 5; x++) begin
      if (mem_req !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("err_quiet", bad, 0);
    chk("err_pulse_end", err, 1'b0);

    // Overflow: wrap vs saturate.
    load(1, 8, 8, 2);
    go(1, 8, 8, 1'b1);
    wait_done(cyc);
    check_c(1, 8);
    w = mem[C_BASE]; e0 = w[EW-1:0];
`ifdef MM_SATURATE_EN
    chk("overflow_elem", e0, 32'h7FFF_FFFF);
`else
    chk("overflow_elem", e0, 32'hFFFF_FFF0);
`endif

    // Random products with random waits.
    max_wait = 2;
    for (int t = 0; t < 3; t++) begin
      m = int'($urandom_range(3, 1));
      k = LANES * int'($urandom_range(2, 1));
      n = LANES * int'($urandom_range(2, 1));
      load(m, k, n, 3);
      go(m, k, n, 1'b1);
      wait_done(cyc);
      chk("accesses_rand", acks, n_access(m, k, n));
      chk("stable_rand", stab_bad, 0);
      check_c(m, n);
    end

    // Reset while a B read is waiting for ack, then a full rerun.
    max_wait = 0; ack_limit = 2;
    load(1, 8, 8, 3);
    go(1, 8, 8, 1'b1);
    cyc = 0;
    while (acks < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    chk("stalled_req", mem_req, 1'b1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_req", mem_req, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_addr", mem_addr, '0);
    @(negedge clk); reset = 1'b1; ack_limit = -1;
    go(1, 8, 8, 1'b1);
    wait_done(cyc);
    chk("accesses_rerun", acks, n_access(1, 8, 8));
    check_c(1, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
